// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state encoding,
// transaction owner, and the default anti-starvation limit.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ_I = 3'd1,
    ST_REQ_D = 3'd2,
    ST_RSP_I = 3'd3,
    ST_RSP_D = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int DEFAULT_MAX_D_STREAK = 4;

endpackage

// File: rtl/arb_streak_counter.sv
// Saturating counter of consecutive data-side grants taken while the
// instruction side was waiting; sat tells the arbiter to let I go next.
module arb_streak_counter #(
  parameter int MAX_CNT = 4,
  parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [CNT_W-1:0] cnt_q;

  assign sat = (cnt_q == CNT_W'(MAX_CNT));

  // clear dominates so an I grant in the same cycle always restarts the streak
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !sat) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and memory stage (D): one outstanding
// transaction, D priority, I forced ahead after MAX_D_STREAK consecutive D wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = DEFAULT_MAX_D_STREAK
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [3:0]            dm_be_i,
  input  logic [DATA_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  err_o
);

  arb_state_e state_q, state_d;
  owner_e     owner;
  logic       streak_sat;
  logic       any_req;
  logic       pick_d;
  logic       grant;
  logic       in_rsp;
  logic       rsp_pulse;
  logic       owner_d;
  logic       err_q;

  assign any_req = if_req_i | dm_req_i;
  assign pick_d  = dm_req_i & ~(streak_sat & if_req_i);

  // Owner is chosen only in IDLE; REQ_x/RSP_x freeze it until the response returns
  always_comb begin
    state_d   = state_q;
    owner     = OWN_I;
    mem_req_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        owner     = pick_d ? OWN_D : OWN_I;
        mem_req_o = any_req;
        if (any_req) begin
          if (mem_gnt_i) state_d = pick_d ? ST_RSP_D : ST_RSP_I;
          else           state_d = pick_d ? ST_REQ_D : ST_REQ_I;
        end
      end
      ST_REQ_I: begin
        owner     = OWN_I;
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = ST_RSP_I;
      end
      ST_REQ_D: begin
        owner     = OWN_D;
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = ST_RSP_D;
      end
      ST_RSP_I: begin
        owner = OWN_I;
        if (mem_rvalid_i) state_d = ST_IDLE;
      end
      ST_RSP_D: begin
        owner = OWN_D;
        if (mem_rvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign owner_d   = (owner == OWN_D);
  assign grant     = mem_req_o & mem_gnt_i;
  assign in_rsp    = (state_q == ST_RSP_I) || (state_q == ST_RSP_D);
  assign rsp_pulse = in_rsp & mem_rvalid_i;

  assign if_gnt_o    = grant & ~owner_d;
  assign dm_gnt_o    = grant &  owner_d;
  assign if_rvalid_o = rsp_pulse & ~owner_d;
  assign dm_rvalid_o = rsp_pulse &  owner_d;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

  // Memory-side fields are zeroed whenever no request is presented
  assign mem_we_o    = mem_req_o & owner_d & dm_we_i;
  assign mem_be_o    = !mem_req_o ? 4'h0 : (owner_d ? dm_be_i : 4'hF);
  assign mem_addr_o  = !mem_req_o ? '0 : (owner_d ? dm_addr_i : if_addr_i);
  assign mem_wdata_o = (mem_req_o && owner_d) ? dm_wdata_i : '0;

  arb_streak_counter #(
    .MAX_CNT (MAX_D_STREAK)
  ) u_streak (
    .clk (clk),
    .rst (rst),
    .inc (dm_gnt_o & if_req_i),
    .clr (if_gnt_o | ~if_req_i),
    .sat (streak_sat)
  );

  // A response with nothing outstanding is latched until the next reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err_q <= 1'b0;
    else if (mem_rvalid_i && !in_rsp) err_q <= 1'b1;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-driven memory responses, outputs
// checked mid-cycle against hand-computed values.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i, dm_we_i;
  logic [3:0]  dm_be_i;
  logic [31:0] dm_addr_i, dm_wdata_i;
  logic        dm_gnt_o, dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int compared   = 0;
  int mismatched = 0;

  mem_port_arbiter #(.DATA_WIDTH(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
    .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_order [6];

  initial begin
    rst = 1'b1;
    if_req_i = 0; if_addr_i = 0;
    dm_req_i = 0; dm_we_i = 0; dm_be_i = 0; dm_addr_i = 0; dm_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    tick(); tick();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_gnts", {if_gnt_o, dm_gnt_o}, 0);
    chk("rst_rvalids", {if_rvalid_o, dm_rvalid_o}, 0);
    chk("rst_rdata", if_rdata_o | dm_rdata_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;
    tick();

    // 1: I only, granted immediately, data two cycles later
    if_req_i = 1; if_addr_i = 32'h10; mem_gnt_i = 1; #1;
    chk("t1_if_gnt", if_gnt_o, 1);
    chk("t1_dm_gnt", dm_gnt_o, 0);
    chk("t1_mem_req", mem_req_o, 1);
    chk("t1_mem_addr", mem_addr_o, 32'h10);
    chk("t1_mem_we", mem_we_o, 0);
    tick();
    if_req_i = 0; mem_gnt_i = 0; #1;
    chk("t1_rsp_mem_req", mem_req_o, 0);
    chk("t1_rsp_wait", if_rvalid_o, 0);
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; #1;
    chk("t1_if_rvalid", if_rvalid_o, 1);
    chk("t1_if_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("t1_dm_rvalid", dm_rvalid_o, 0);
    chk("t1_dm_rdata", dm_rdata_o, 0);
    tick();
    mem_rvalid_i = 0; #1;
    chk("t1_after_rvalid", if_rvalid_o, 0);
    chk("t1_after_rdata", if_rdata_o, 0);
    tick();

    // 2: simultaneous I+D, D first, I right after D's response
    if_req_i = 1; if_addr_i = 32'h20;
    dm_req_i = 1; dm_addr_i = 32'h100; dm_we_i = 0; dm_be_i = 4'hF;
    mem_gnt_i = 1; #1;
    chk("t2_dm_gnt", dm_gnt_o, 1);
    chk("t2_if_gnt", if_gnt_o, 0);
    chk("t2_mem_addr", mem_addr_o, 32'h100);
    tick();
    dm_req_i = 0; mem_gnt_i = 0; #1;
    chk("t2_rsp_if_gnt", if_gnt_o, 0);
    chk("t2_rsp_mem_req", mem_req_o, 0);
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE0001; #1;
    chk("t2_dm_rvalid", dm_rvalid_o, 1);
    chk("t2_dm_rdata", dm_rdata_o, 32'hCAFE0001);
    chk("t2_if_rvalid", if_rvalid_o, 0);
    chk("t2_if_rdata", if_rdata_o, 0);
    tick();
    mem_rvalid_i = 0; mem_gnt_i = 1; #1;
    chk("t2_if_gnt_next", if_gnt_o, 1);
    chk("t2_if_addr", mem_addr_o, 32'h20);
    tick();
    if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55; #1;
    chk("t2_if_rvalid", if_rvalid_o, 1);
    chk("t2_if_rdata", if_rdata_o, 32'h55);
    tick();
    mem_rvalid_i = 0;
    tick();

    // 3: both held high; {if_gnt, dm_gnt} per transaction
    exp_order[0] = 2'b01; exp_order[1] = 2'b01; exp_order[2] = 2'b01;
    exp_order[3] = 2'b01; exp_order[4] = 2'b10; exp_order[5] = 2'b01;
    if_req_i = 1; if_addr_i = 32'h40;
    dm_req_i = 1; dm_addr_i = 32'h200;
    for (int t = 0; t < 6; t++) begin
      mem_gnt_i = 1; mem_rvalid_i = 0; #1;
      chk($sformatf("t3_order_%0d", t), {if_gnt_o, dm_gnt_o}, exp_order[t]);
      chk($sformatf("t3_addr_%0d", t), mem_addr_o,
          exp_order[t][1] ? 32'h40 : 32'h200);
      tick();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'(t); #1;
      chk($sformatf("t3_rvalid_%0d", t), {if_rvalid_o, dm_rvalid_o}, exp_order[t]);
      tick();
    end
    if_req_i = 0; dm_req_i = 0; mem_rvalid_i = 0;
    tick();

    // 4: backpressure in REQ_D while I raises its request
    dm_req_i = 1; dm_addr_i = 32'h300; mem_gnt_i = 0; #1;
    chk("t4_c0_mem_req", mem_req_o, 1);
    chk("t4_c0_addr", mem_addr_o, 32'h300);
    chk("t4_c0_dm_gnt", dm_gnt_o, 0);
    tick();
    if_req_i = 1; if_addr_i = 32'h44;
    for (int c = 1; c < 3; c++) begin
      #1;
      chk($sformatf("t4_c%0d_addr", c), mem_addr_o, 32'h300);
      chk($sformatf("t4_c%0d_gnts", c), {if_gnt_o, dm_gnt_o}, 2'b00);
      tick();
    end
    mem_gnt_i = 1; #1;
    chk("t4_c3_dm_gnt", dm_gnt_o, 1);
    chk("t4_c3_if_gnt", if_gnt_o, 0);
    chk("t4_c3_addr", mem_addr_o, 32'h300);
    tick();
    dm_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h77; #1;
    chk("t4_dm_rvalid", dm_rvalid_o, 1);
    tick();
    mem_rvalid_i = 0; mem_gnt_i = 1; #1;
    chk("t4_if_gnt", if_gnt_o, 1);
    tick();
    if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h88; #1;
    chk("t4_if_rdata", if_rdata_o, 32'h88);
    tick();
    mem_rvalid_i = 0;
    tick();

    // 5: byte-enabled write, acknowledged through rvalid
    dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'b0011;
    dm_addr_i = 32'h400; dm_wdata_i = 32'h1234; mem_gnt_i = 1; #1;
    chk("t5_dm_gnt", dm_gnt_o, 1);
    chk("t5_mem_we", mem_we_o, 1);
    chk("t5_mem_be", mem_be_o, 4'b0011);
    chk("t5_mem_wdata", mem_wdata_o, 32'h1234);
    tick();
    dm_req_i = 0; dm_we_i = 0; dm_be_i = 0; dm_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 1; #1;
    chk("t5_dm_rvalid", dm_rvalid_o, 1);
    chk("t5_if_rvalid", if_rvalid_o, 0);
    tick();
    mem_rvalid_i = 0; #1;
    chk("t5_err_clean", err_o, 0);
    tick();

    // 6: reset during RSP_I, then a stale response
    if_req_i = 1; if_addr_i = 32'h80; mem_gnt_i = 1; #1;
    chk("t6_if_gnt", if_gnt_o, 1);
    tick();
    if_req_i = 0; mem_gnt_i = 0; rst = 1; #1;
    chk("t6_rst_mem_req", mem_req_o, 0);
    chk("t6_rst_rvalid", if_rvalid_o, 0);
    tick();
    rst = 0;
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'hBAD; #1;
    chk("t6_no_if_rvalid", if_rvalid_o, 0);
    chk("t6_no_if_rdata", if_rdata_o, 0);
    chk("t6_err_not_yet", err_o, 0);
    tick();
    mem_rvalid_i = 0; dm_req_i = 1; dm_addr_i = 32'h500; mem_gnt_i = 1; #1;
    chk("t6_err_set", err_o, 1);
    chk("t6_idle_dm_gnt", dm_gnt_o, 1);
    tick();
    dm_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h99; #1;
    chk("t6_dm_rvalid", dm_rvalid_o, 1);
    chk("t6_err_sticky", err_o, 1);
    tick();
    mem_rvalid_i = 0;
    tick();
    #1;
    chk("t6_err_held", err_o, 1);
    rst = 1; #1;
    chk("t6_err_cleared", err_o, 0);
    tick();
    rst = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
